// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data
// load/store requesters. A single transaction is outstanding at a time. It is
// aborted after TIMEOUT wait cycles and finishes with a one-cycle ack.
// Optional build macro: MEM_ARBITER_RR_EN replaces the default fixed priority
// (data over fetch) with round-robin arbitration between the two requesters.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_wstrb,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        dm_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY, RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_d, mem_we_d;
  logic [31:0]       mem_addr_d, mem_wdata_d;
  logic [3:0]        mem_wstrb_d;
  logic              if_ack_d, if_err_d, dm_ack_d, dm_err_d;
  logic [31:0]       if_rdata_d, dm_rdata_d;
  logic              grant_dm_c;

`ifdef MEM_ARBITER_RR_EN
  // Set when the data requester received the most recent grant.
  logic last_dm_q, last_dm_d;

  // Round-robin: on contention the requester not granted last wins.
  always_comb grant_dm_c = dm_req && (!if_req || !last_dm_q);
`else
  // Fixed priority: data wins whenever it is requesting.
  always_comb grant_dm_c = dm_req;
`endif

  // State and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      if_ack    <= 1'b0;
      if_err    <= 1'b0;
      dm_ack    <= 1'b0;
      dm_err    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
`ifdef MEM_ARBITER_RR_EN
      last_dm_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_wstrb <= mem_wstrb_d;
      if_ack    <= if_ack_d;
      if_err    <= if_err_d;
      dm_ack    <= dm_ack_d;
      dm_err    <= dm_err_d;
      if_rdata  <= if_rdata_d;
      dm_rdata  <= dm_rdata_d;
`ifdef MEM_ARBITER_RR_EN
      last_dm_q <= last_dm_d;
`endif
    end
  end

  // Next-state and next-output logic; acks/errs are single-cycle by default.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_wstrb_d = mem_wstrb;
    if_ack_d    = 1'b0;
    if_err_d    = 1'b0;
    dm_ack_d    = 1'b0;
    dm_err_d    = 1'b0;
    if_rdata_d  = if_rdata;
    dm_rdata_d  = dm_rdata;
`ifdef MEM_ARBITER_RR_EN
    last_dm_d   = last_dm_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (dm_req || if_req) begin
          cnt_d     = '0;
          mem_req_d = 1'b1;
`ifdef MEM_ARBITER_RR_EN
          last_dm_d = grant_dm_c;
`endif
          if (grant_dm_c) begin
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            mem_wstrb_d = dm_wstrb;
            state_d     = DM_BUSY;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
            state_d     = IF_BUSY;
          end
        end
      end

      IF_BUSY, DM_BUSY: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (state_q == DM_BUSY) begin
            dm_rdata_d = mem_rdata;
            dm_ack_d   = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_WAIT) begin
            mem_req_d = 1'b0;
            state_d   = RESP;
            if (state_q == DM_BUSY) begin
              dm_ack_d = 1'b1;
              dm_err_d = 1'b1;
            end else begin
              if_ack_d = 1'b1;
              if_err_d = 1'b1;
            end
          end
        end
      end

      RESP: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Transaction-level bench for mem_arbiter: drives requesters and a memory
// responder with random latencies and checks against a per-transaction model.
module tb_mem_arbiter;

  localparam int unsigned TO = 16;

  logic        clk, rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack, if_err;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_rdata;
  logic        dm_ack, dm_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_if_rdata, m_dm_rdata;
  logic        m_last_dm;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ack(if_ack), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_err(dm_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One arbitration + memory transaction. lat=1: called at a negedge of an
  // IDLE cycle; lat=2: called at the negedge of the previous RESP cycle.
  // w = wait cycles before mem_ready (w >= TO means the memory never answers).
  task automatic run_txn(input logic ir, input logic dr, input logic [31:0] ia,
                         input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
                         input logic [3:0] ds, input int w, input logic [31:0] rd,
                         input int lat, output logic win_dm);
    logic [68:0] exp_pl;
    logic        done;
    logic        succ;
    if_req = ir; if_addr = ia;
    dm_req = dr; dm_we = dwe; dm_addr = da; dm_wdata = dwd; dm_wstrb = ds;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    if (ir && dr) win_dm = !m_last_dm;
    else          win_dm = dr;
`ifndef MEM_ARBITER_RR_EN
    win_dm = dr;
`endif
    exp_pl = win_dm ? {dwe, ds, da, dwd} : {1'b0, 4'h0, ia, 32'h0};
    if (lat == 2) begin
      @(negedge clk);
      check("idle_req", 96'(mem_req), 96'(0));
      check("idle_ack", 96'({if_ack, dm_ack}), 96'(0));
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end
    @(negedge clk);
    m_last_dm = win_dm;
    done = 1'b0;
    for (int k = 1; k <= int'(TO) && !done; k++) begin
      check("busy_req", 96'(mem_req), 96'(1));
      check("busy_payload", 96'({mem_we, mem_wstrb, mem_addr, mem_wdata}), 96'(exp_pl));
      check("busy_ack", 96'({if_ack, dm_ack, if_err, dm_err}), 96'(0));
      mem_ready = (k == w + 1);
      mem_rdata = mem_ready ? rd : $urandom;
      if (win_dm) if_addr = $urandom;
      else begin
        dm_addr = $urandom; dm_wdata = $urandom;
        dm_wstrb = 4'($urandom); dm_we = 1'($urandom);
      end
      done = mem_ready;
      @(negedge clk);
    end
    succ = (w < int'(TO));
    if (succ) begin
      if (win_dm) m_dm_rdata = rd;
      else        m_if_rdata = rd;
    end
    check("resp_req", 96'(mem_req), 96'(0));
    check("resp_ack", 96'({if_ack, dm_ack}), win_dm ? 96'(2'b01) : 96'(2'b10));
    check("resp_err", 96'({if_err, dm_err}),
          !succ ? (win_dm ? 96'(2'b01) : 96'(2'b10)) : 96'(0));
    check("resp_rdata", 96'({if_rdata, dm_rdata}), 96'({m_if_rdata, m_dm_rdata}));
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
  endtask

  initial begin
    logic       win;
    logic [5:0] seq;
    int         ic, dc, w, sel;
    logic       ir, dr;

    rst = 1'b1;
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0;
    dm_wdata = 0; dm_wstrb = 0; mem_rdata = 0; mem_ready = 0;
    m_if_rdata = 0; m_dm_rdata = 0; m_last_dm = 0;
    repeat (2) @(negedge clk);
    check("rst_out_a", 96'({if_rdata, dm_rdata, if_ack, if_err, dm_ack, dm_err}), 96'(0));
    check("rst_out_b", 96'({mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata}), 96'(0));
    rst = 1'b0;
    @(negedge clk);
    check("idle_out", 96'({mem_req, if_ack, dm_ack}), 96'(0));

    // Fetch with single-cycle memory response
    run_txn(1, 0, 32'h100, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1, win);
    // Store with three wait cycles
    run_txn(0, 1, 0, 1, 32'h2000, 32'h12345678, 4'hF, 3, 32'h0BAD0BAD, 2, win);
    // Timeout: memory never answers, dm_rdata must be unchanged
    run_txn(0, 1, 0, 0, 32'h40, 0, 0, int'(TO), 32'h11111111, 2, win);
    // Ready on the final allowed wait cycle is success
    run_txn(0, 1, 0, 0, 32'h44, 0, 0, int'(TO) - 1, 32'h22222222, 2, win);

    // Asynchronous reset during a fetch
    if_req = 1; dm_req = 0; if_addr = 32'h300; mem_ready = 0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_req", 96'(mem_req), 96'(1));
    #2 rst = 1'b1;
    #1;
    check("async_rst_a", 96'({if_rdata, dm_rdata, if_ack, if_err, dm_ack, dm_err}), 96'(0));
    check("async_rst_b", 96'({mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata}), 96'(0));
    @(negedge clk);
    check("rst_no_ack", 96'({if_ack, dm_ack}), 96'(0));
    rst = 1'b0;
    m_if_rdata = 0; m_dm_rdata = 0; m_last_dm = 0;
    @(negedge clk);
    check("regrant_req", 96'({mem_req, mem_addr}), 96'({1'b1, 32'h300}));
    mem_ready = 1; mem_rdata = 32'hA5A50001;
    @(negedge clk);
    m_if_rdata = 32'hA5A50001;
    check("regrant_ack", 96'({if_ack, dm_ack, if_err}), 96'(3'b100));
    check("regrant_rdata", 96'({if_rdata, dm_rdata}), 96'({m_if_rdata, m_dm_rdata}));
    mem_ready = 0;

    // Both requesters hold three transactions each
    ic = 3; dc = 3; seq = '0;
    for (int t = 0; t < 6; t++) begin
      run_txn(ic > 0, dc > 0, $urandom, 1'($urandom), $urandom, $urandom,
              4'($urandom), $urandom_range(0, 2), $urandom, 2, win);
      seq = {seq[4:0], win};
      if (win) dc--; else ic--;
    end
`ifdef MEM_ARBITER_RR_EN
    check("grant_order", 96'(seq), 96'(6'b101010));
`else
    check("grant_order", 96'(seq), 96'(6'b111000));
`endif

    // Random traffic
    for (int t = 0; t < 40; t++) begin
      ir  = 1'($urandom_range(0, 1));
      dr  = ir ? 1'($urandom_range(0, 1)) : 1'b1;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       w = int'(TO) - 1;
        1:       w = int'(TO);
        2:       w = int'(TO) + 1;
        default: w = $urandom_range(0, 4);
      endcase
      run_txn(ir, dr, $urandom, 1'($urandom), $urandom, $urandom,
              4'($urandom), w, $urandom, 2, win);
    end

    if_req = 0; dm_req = 0; mem_ready = 0;
    @(negedge clk);
    check("final_idle", 96'({mem_req, if_ack, dm_ack}), 96'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
